ext_pipe: RTL and testbench

Parametrised, pipelined load/immediate extender: selects a byte, halfword or word lane from a data beat using the low address bits, then sign- or zero-extends it (or forms a LUI value) to `DATA_W`. It sits between the data-memory read port / immediate field and the writeback/ALU-operand path. It replaces the single fixed 16→32 sign extender with one registered stage that handles all load and immediate extension modes. It has a valid/ready handshake and a two-entry skid buffer, so back-pressure never drops a beat.

---
 rtl/ext_pipe_pkg.sv | 10 +
 rtl/ext_pipe_if.sv | 23 ++
 rtl/ext_pipe_lane_sel.sv | 42 ++++
 rtl/ext_pipe.sv | 68 ++++++
 tb/tb_ext_pipe.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/ext_pipe_pkg.sv
// ext_pkg: shared mode encoding, occupancy states and width check for ext_pipe
package ext_pkg;
  typedef enum logic [2:0] {
    M_LW, M_LB, M_LBU, M_LH, M_LHU, M_SEXT16, M_ZEXT16, M_LUI
  } ext_mode_t;
  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} occ_t;
  function automatic bit data_w_ok(input int w);
    return w == 32 || w == 64;
  endfunction
endpackage

// File: rtl/ext_pipe_if.sv
// ext_pipe_if: input beat and output result handshake bundle for ext_pipe
interface ext_pipe_if import ext_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int OFF_W  = $clog2(DATA_W/8)
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [OFF_W-1:0]  in_off;
  ext_mode_t         in_mode;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_misalign;
  modport master (
    output in_valid, in_data, in_off, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_misalign
  );
  modport slave (
    input  in_valid, in_data, in_off, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_misalign
  );
endinterface

// File: rtl/ext_pipe_lane_sel.sv
// ext_lane_sel: combinational lane select, sign/zero extend and misalign detect
module ext_lane_sel import ext_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int OFF_W  = $clog2(DATA_W/8)
) (
  input  logic [DATA_W-1:0] i_data,
  input  logic [OFF_W-1:0]  i_off,
  input  ext_mode_t         i_mode,
  output logic [DATA_W-1:0] o_data,
  output logic              o_misalign
);
  logic [DATA_W-1:0] w_sh, w_lw, w_lb, w_lbu, w_lh, w_lhu, w_sx, w_zx, w_lui, w_ext;
  logic [7:0]  w_b;
  logic [15:0] w_h, w_i;
  logic [31:0] w_w;
  // shifting the beat down puts the addressed byte at bit 0
  assign w_sh  = i_data >> {i_off, 3'b000};
  assign w_b   = w_sh[7:0];
  assign w_h   = w_sh[15:0];
  assign w_w   = w_sh[31:0];
  assign w_i   = i_data[15:0];
  assign w_lw  = DATA_W'($signed(w_w));
  assign w_lb  = DATA_W'($signed(w_b));
  assign w_lbu = DATA_W'(w_b);
  assign w_lh  = DATA_W'($signed(w_h));
  assign w_lhu = DATA_W'(w_h);
  assign w_sx  = DATA_W'($signed(w_i));
  assign w_zx  = DATA_W'(w_i);
  assign w_lui = DATA_W'($signed({w_i, 16'h0000}));
  always_comb begin
    w_ext = i_mode == M_LW     ? w_lw  :
            i_mode == M_LB     ? w_lb  :
            i_mode == M_LBU    ? w_lbu :
            i_mode == M_LH     ? w_lh  :
            i_mode == M_LHU    ? w_lhu :
            i_mode == M_SEXT16 ? w_sx  :
            i_mode == M_ZEXT16 ? w_zx  : w_lui;
    o_misalign = ((i_mode == M_LH || i_mode == M_LHU) && i_off[0]) ||
                 (i_mode == M_LW && i_off[1:0] != 2'b00);
    o_data = o_misalign ? '0 : w_ext;
  end
endmodule

// File: rtl/ext_pipe.sv
// ext_pipe: registered load/immediate extender with a two-entry skid buffer
module ext_pipe import ext_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int OFF_W  = $clog2(DATA_W/8)
) (
  input  logic       clk,
  input  logic       rst,
  ext_pipe_if.slave  io_bus
);
  if (!data_w_ok(DATA_W)) begin : g_bad_w
    $error("ext_pipe: DATA_W must be 32 or 64");
  end
  occ_t              r_state, w_next;
  logic              r_in_ready, r_m_mis, r_s_mis, w_mis, w_acc, w_drn, w_out_valid;
  logic [DATA_W-1:0] r_m_data, r_s_data, w_data;
  ext_lane_sel #(.DATA_W(DATA_W), .OFF_W(OFF_W)) u_sel (
    .i_data    (io_bus.in_data),
    .i_off     (io_bus.in_off),
    .i_mode    (io_bus.in_mode),
    .o_data    (w_data),
    .o_misalign(w_mis)
  );
  assign w_out_valid = r_state != S_EMPTY;
  assign w_acc       = io_bus.in_valid & r_in_ready;
  assign w_drn       = w_out_valid & io_bus.out_ready;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_EMPTY;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_next;
      r_in_ready <= w_next != S_TWO;
    end
  end
  always_comb begin
    w_next = r_state == S_EMPTY ? (w_acc ? S_ONE : S_EMPTY) :
             r_state == S_ONE   ? ((w_acc && !w_drn) ? S_TWO :
                                   (!w_acc && w_drn) ? S_EMPTY : S_ONE) :
                                  (w_drn ? S_ONE : S_TWO);
  end
  // an accept with the main entry busy and not draining can only happen in ONE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_m_data <= '0;
      r_m_mis  <= 1'b0;
      r_s_data <= '0;
      r_s_mis  <= 1'b0;
    end else begin
      if (w_acc && (r_state == S_EMPTY || w_drn)) begin
        r_m_data <= w_data;
        r_m_mis  <= w_mis;
      end else if (w_drn && r_state == S_TWO) begin
        r_m_data <= r_s_data;
        r_m_mis  <= r_s_mis;
      end
      if (w_acc && r_state == S_ONE && !w_drn) begin
        r_s_data <= w_data;
        r_s_mis  <= w_mis;
      end
    end
  end
  always_comb begin
    io_bus.in_ready     = r_in_ready;
    io_bus.out_valid    = w_out_valid;
    io_bus.out_data     = r_m_data;
    io_bus.out_misalign = r_m_mis;
  end
endmodule

// File: tb/tb_ext_pipe.sv
// tb_ext_pipe: directed and randomized self-checking bench for ext_pipe
module tb_ext_pipe;
  import ext_pkg::*;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  ext_pipe_if #(.DATA_W(32)) b32();
  ext_pipe_if #(.DATA_W(64)) b64();
  ext_pipe #(.DATA_W(32)) u_dut32 (.clk(clk), .rst(rst), .io_bus(b32));
  ext_pipe #(.DATA_W(64)) u_dut64 (.clk(clk), .rst(rst), .io_bus(b64));
  function automatic void ref_ext(input logic [31:0] d, input logic [1:0] off,
                                  input logic [2:0] m, output logic [31:0] r,
                                  output logic mis);
    logic [7:0] b [4];
    logic [1:0] o1;
    for (int i = 0; i < 4; i++) b[i] = d[8*i +: 8];
    o1 = off + 2'd1;
    mis = 1'b0;
    case (m)
      3'd0: begin mis = off != 2'd0; r = d; end
      3'd1: r = {{24{b[off][7]}}, b[off]};
      3'd2: r = {24'h0, b[off]};
      3'd3: begin mis = off[0]; r = {{16{b[o1][7]}}, b[o1], b[off]}; end
      3'd4: begin mis = off[0]; r = {16'h0, b[o1], b[off]}; end
      3'd5: r = {{16{d[15]}}, d[15:0]};
      3'd6: r = {16'h0, d[15:0]};
      default: r = {d[15:0], 16'h0};
    endcase
    if (mis) r = 32'h0;
  endfunction
  task automatic drive(input logic [31:0] d, input logic [1:0] off, input logic [2:0] m);
    b32.in_valid = 1'b1;
    b32.in_data  = d;
    b32.in_off   = off;
    b32.in_mode  = ext_mode_t'(m);
  endtask
  task automatic test_reset();
    rst = 1'b1;
    b32.in_valid = 1'b0; b32.out_ready = 1'b1;
    b32.in_data = '0; b32.in_off = '0; b32.in_mode = M_LW;
    b64.in_valid = 1'b0; b64.out_ready = 1'b1;
    b64.in_data = '0; b64.in_off = '0; b64.in_mode = M_LW;
    #12;
    checks += 4;
    if (b32.out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid: got %b want 0", b32.out_valid); end
    if (b32.in_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready: got %b want 1", b32.in_ready); end
    if (b32.out_data !== 32'h0) begin errors++; $display("FAIL reset out_data: got %h want 0", b32.out_data); end
    if (b32.out_misalign !== 1'b0) begin errors++; $display("FAIL reset out_misalign: got %b want 0", b32.out_misalign); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask
  task automatic test_lanes();
    logic [1:0]  offs [8] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd1, 2'd2, 2'd3};
    logic [2:0]  mds  [8] = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd3, 3'd0, 3'd1};
    logic [31:0] exd  [8] = '{32'h0000_007F, 32'hFFFF_FFF1, 32'h0000_00F1, 32'hFFFF_8234,
                              32'h0000_8234, 32'h0, 32'h0, 32'hFFFF_FF82};
    logic        exm  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    b32.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(32'h8234_F17F, offs[i], mds[i]);
      checks++;
      if (b32.in_ready !== 1'b1) begin errors++; $display("FAIL lane%0d in_ready: got %b want 1", i, b32.in_ready); end
      @(posedge clk); #1;
      b32.in_valid = 1'b0;
      checks += 3;
      if (b32.out_valid !== 1'b1) begin errors++; $display("FAIL lane%0d out_valid: got %b want 1", i, b32.out_valid); end
      if (b32.out_data !== exd[i]) begin errors++; $display("FAIL lane%0d out_data: got %h want %h", i, b32.out_data, exd[i]); end
      if (b32.out_misalign !== exm[i]) begin errors++; $display("FAIL lane%0d out_misalign: got %b want %b", i, b32.out_misalign, exm[i]); end
    end
    @(posedge clk); #1;
  endtask
  task automatic test_imm();
    logic [2:0]  mds [3] = '{3'd5, 3'd6, 3'd7};
    logic [31:0] exd [3] = '{32'hFFFF_8001, 32'h0000_8001, 32'h8001_0000};
    for (int i = 0; i < 3; i++) begin
      drive(32'h0000_8001, 2'd3, mds[i]);
      @(posedge clk); #1;
      b32.in_valid = 1'b0;
      checks += 2;
      if (b32.out_data !== exd[i]) begin errors++; $display("FAIL imm%0d out_data: got %h want %h", i, b32.out_data, exd[i]); end
      if (b32.out_misalign !== 1'b0) begin errors++; $display("FAIL imm%0d out_misalign: got %b want 0", i, b32.out_misalign); end
    end
    b64.in_valid = 1'b1; b64.in_data = 64'h0000_0000_0000_8001; b64.in_off = 3'd0; b64.in_mode = M_LUI;
    @(posedge clk); #1;
    b64.in_valid = 1'b0;
    checks += 2;
    if (b64.out_valid !== 1'b1) begin errors++; $display("FAIL lui64 out_valid: got %b want 1", b64.out_valid); end
    if (b64.out_data !== 64'hFFFF_FFFF_8001_0000) begin errors++; $display("FAIL lui64 out_data: got %h want ffffffff80010000", b64.out_data); end
    @(posedge clk); #1;
  endtask
  task automatic test_back_to_back();
    logic [1:0]  offs [4] = '{2'd0, 2'd1, 2'd2, 2'd2};
    logic [2:0]  mds  [4] = '{3'd1, 3'd1, 3'd3, 3'd4};
    logic [31:0] exd  [4] = '{32'h0000_007F, 32'hFFFF_FFF1, 32'hFFFF_8234, 32'h0000_8234};
    int sent = 0, got = 0, cyc = 0;
    logic acc, drn;
    logic [31:0] od;
    b32.out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      drive(32'h8234_F17F, offs[sent], mds[sent]);
      acc = b32.in_ready;
      @(posedge clk); #1;
      if (acc) sent++;
    end
    checks += 3;
    if (sent != 2) begin errors++; $display("FAIL bp accepted: got %0d want 2", sent); end
    if (b32.in_ready !== 1'b0) begin errors++; $display("FAIL bp in_ready: got %b want 0", b32.in_ready); end
    if (b32.out_data !== exd[0]) begin errors++; $display("FAIL bp hold: got %h want %h", b32.out_data, exd[0]); end
    b32.out_ready = 1'b1;
    while (got < 4 && cyc < 20) begin
      if (sent < 4) drive(32'h8234_F17F, offs[sent], mds[sent]);
      else b32.in_valid = 1'b0;
      acc = b32.in_valid && b32.in_ready;
      drn = b32.out_valid && b32.out_ready;
      od  = b32.out_data;
      @(posedge clk); #1;
      cyc++;
      if (drn) begin
        checks++;
        if (od !== exd[got]) begin errors++; $display("FAIL bp beat%0d: got %h want %h", got, od, exd[got]); end
        got++;
      end
      if (acc) sent++;
    end
    b32.in_valid = 1'b0;
    checks++;
    if (got != 4) begin errors++; $display("FAIL bp delivered: got %0d want 4", got); end
    @(posedge clk); #1;
    checks++;
    if (b32.out_valid !== 1'b0) begin errors++; $display("FAIL bp duplicate: out_valid %b want 0", b32.out_valid); end
  endtask
  task automatic test_random();
    logic [31:0] q_d [$];
    logic        q_m [$];
    logic [31:0] nd, ed, od;
    logic [1:0]  no;
    logic [2:0]  nm;
    logic        em, om, acc, drn;
    int sent = 0, got = 0, cyc = 0;
    nd = $urandom; no = 2'($urandom_range(0, 3)); nm = 3'($urandom_range(0, 7));
    while (got < 1000 && cyc < 20000) begin
      drive(nd, no, nm);
      b32.in_valid  = (sent < 1000) && ($urandom_range(0, 3) != 0);
      b32.out_ready = $urandom_range(0, 2) != 0;
      acc = b32.in_valid && b32.in_ready;
      drn = b32.out_valid && b32.out_ready;
      od = b32.out_data; om = b32.out_misalign;
      @(posedge clk); #1;
      cyc++;
      if (drn) begin
        checks++;
        if (q_d.size() == 0) begin
          errors++; $display("FAIL rand extra beat: got %h want none", od);
        end else begin
          ed = q_d.pop_front(); em = q_m.pop_front();
          if (od !== ed || om !== em) begin errors++; $display("FAIL rand beat%0d: got %h/%b want %h/%b", got, od, om, ed, em); end
        end
        got++;
      end
      if (acc) begin
        ref_ext(nd, no, nm, ed, em);
        q_d.push_back(ed); q_m.push_back(em);
        sent++;
        nd = $urandom; no = 2'($urandom_range(0, 3)); nm = 3'($urandom_range(0, 7));
      end
    end
    b32.in_valid = 1'b0; b32.out_ready = 1'b1;
    checks++;
    if (got != 1000 || q_d.size() != 0) begin errors++; $display("FAIL rand count: got %0d left %0d want 1000 left 0", got, q_d.size()); end
    @(posedge clk); #1;
  endtask
  task automatic test_reset_two();
    b32.out_ready = 1'b0;
    drive(32'h1111_1111, 2'd0, 3'd0);
    @(posedge clk); #1;
    drive(32'h2222_2222, 2'd0, 3'd0);
    @(posedge clk); #1;
    b32.in_valid = 1'b0;
    checks += 2;
    if (b32.in_ready !== 1'b0) begin errors++; $display("FAIL two in_ready: got %b want 0", b32.in_ready); end
    if (b32.out_valid !== 1'b1) begin errors++; $display("FAIL two out_valid: got %b want 1", b32.out_valid); end
    #1 rst = 1'b1;
    #1;
    checks += 3;
    if (b32.out_valid !== 1'b0) begin errors++; $display("FAIL arst out_valid: got %b want 0", b32.out_valid); end
    if (b32.in_ready !== 1'b1) begin errors++; $display("FAIL arst in_ready: got %b want 1", b32.in_ready); end
    if (b32.out_data !== 32'h0) begin errors++; $display("FAIL arst out_data: got %h want 0", b32.out_data); end
    #1 rst = 1'b0;
    b32.out_ready = 1'b1;
    drive(32'h8234_F17F, 2'd1, 3'd2);
    @(posedge clk); #1;
    b32.in_valid = 1'b0;
    checks += 2;
    if (b32.out_valid !== 1'b1) begin errors++; $display("FAIL post-rst out_valid: got %b want 1", b32.out_valid); end
    if (b32.out_data !== 32'h0000_00F1) begin errors++; $display("FAIL post-rst out_data: got %h want 000000f1", b32.out_data); end
    @(posedge clk); #1;
    checks++;
    if (b32.out_valid !== 1'b0) begin errors++; $display("FAIL post-rst stale: out_valid %b want 0", b32.out_valid); end
  endtask
  initial begin
    test_reset();
    test_lanes();
    test_imm();
    test_back_to_back();
    test_random();
    test_reset_two();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
